// File: rtl/mmio_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mmio_arbiter_pkg
// Shared definitions for the MMIO arbiter:
//   - MMIO register addresses (UART control/RX/TX, cycle and instruction
//     counters, counter reset)
//   - arbiter FSM state encoding
//   - helper to recognise the UART TX data register
// -----------------------------------------------------------------------------
package mmio_arbiter_pkg;

    localparam logic [31:0] UART_CTRL_ADDR = 32'h8000_0000;
    localparam logic [31:0] UART_RX_ADDR   = 32'h8000_0004;
    localparam logic [31:0] UART_TX_ADDR   = 32'h8000_0008;
    localparam logic [31:0] CYCLE_ADDR     = 32'h8000_0010;
    localparam logic [31:0] INST_ADDR      = 32'h8000_0014;
    localparam logic [31:0] CNT_RST_ADDR   = 32'h8000_0018;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_TX = 2'd2
    } arb_state_e;

    // True when the address selects the UART transmit data register.
    function automatic logic is_uart_tx(input logic [31:0] addr);
        return addr == UART_TX_ADDR;
    endfunction

endpackage

// File: rtl/mmio_arbiter_if.sv
// -----------------------------------------------------------------------------
// mmio_arbiter_if
// One requester port of the MMIO arbiter.
//   valid     : requester has an access (held with fields stable until ready)
//   addr      : access address
//   wdata     : write data
//   we        : 1 = write, 0 = read
//   ready     : access accepted this cycle (arbiter -> requester)
//   rsp_valid : one-cycle response pulse (arbiter -> requester)
// Read data and error flag are shared between requesters and live on the
// arbiter top level.
// -----------------------------------------------------------------------------
interface mmio_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              valid;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
    logic              we;
    logic              ready;
    logic              rsp_valid;

    modport master (
        output valid, addr, wdata, we,
        input  ready, rsp_valid
    );

    modport slave (
        input  valid, addr, wdata, we,
        output ready, rsp_valid
    );
endinterface

// File: rtl/mmio_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// mmio_arbiter_rr_arb2
// Two-way round-robin arbiter. A single requester always wins; on a tie the
// requester that was not granted last wins. last_grant resets to 1 so that
// requester 0 wins the first tie after reset.
//   clk, rst    : clock, synchronous active-high reset
//   req_i[1:0]  : request vector
//   update_en_i : commit the current grant into last_grant
//   grant_o[1:0]: one-hot (or zero) grant, combinational
// -----------------------------------------------------------------------------
module mmio_arbiter_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_en_i,
    output logic [1:0] grant_o
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (update_en_i && (grant_o != 2'b00)) begin
            last_grant_d = grant_o[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mmio_arbiter.sv
// -----------------------------------------------------------------------------
// mmio_arbiter
// Shares the single MMIO port between the core memory stage (req0) and the
// debug/bootloader port (req1). Every accepted access drives exactly one
// read or write strobe for one cycle, so a UART RX read consumes one byte.
// Writes to the UART TX register wait for the transmitter to be ready, and
// are dropped with rsp_err after TX_TIMEOUT cycles (0 = wait forever).
// Timing: accept at T, strobe at T+1, response pulse at T+2.
//   clk, rst          : clock, synchronous active-high reset
//   req0, req1        : requester ports (slave side of mmio_arbiter_if)
//   rsp_rdata, rsp_err: shared response data / TX-timeout flag
//   mmio_*_out        : address, write data and strobes to the MMIO decoder
//   mmio_rdata_in     : combinational read data from the MMIO decoder
//   uart_tx_ready_in  : UART transmitter ready
// -----------------------------------------------------------------------------
module mmio_arbiter
    import mmio_arbiter_pkg::*;
#(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int TX_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    mmio_arbiter_if.slave     req0,
    mmio_arbiter_if.slave     req1,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] mmio_addr_out,
    output logic [DWIDTH-1:0] mmio_data_out,
    output logic              mmio_re_out,
    output logic              mmio_we_out,
    input  logic [DWIDTH-1:0] mmio_rdata_in,
    input  logic              uart_tx_ready_in
);

    localparam int                CNT_W      = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;
    localparam bit                TIMEOUT_EN = (TX_TIMEOUT != 0);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'((TX_TIMEOUT > 0) ? (TX_TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    arb_state_e        state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [1:0]        grant;
    logic              arb_update;
    logic [AWIDTH-1:0] sel_addr;
    logic [DWIDTH-1:0] sel_wdata;
    logic              sel_we;

    mmio_arbiter_rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .rst         (rst),
        .req_i       ({req1.valid, req0.valid}),
        .update_en_i (arb_update),
        .grant_o     (grant)
    );

    // Fields of whichever requester is granted this cycle.
    assign sel_addr  = grant[1] ? req1.addr  : req0.addr;
    assign sel_wdata = grant[1] ? req1.wdata : req0.wdata;
    assign sel_we    = grant[1] ? req1.we    : req0.we;

    // The arbiter only offers grants while idle; a grant is an accept.
    assign arb_update = (state_q == ST_IDLE);
    assign req0.ready = arb_update && grant[0];
    assign req1.ready = arb_update && grant[1];

    assign req0.rsp_valid = rsp_valid_q[0];
    assign req1.rsp_valid = rsp_valid_q[1];
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 2'b00;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        mmio_addr_out = '0;
        mmio_data_out = '0;
        mmio_re_out   = 1'b0;
        mmio_we_out   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    we_d    = sel_we;
                    owner_d = grant[1];
                    cnt_d   = '0;
                    if (sel_we && is_uart_tx(32'(sel_addr)) && !uart_tx_ready_in) begin
                        state_d = ST_WAIT_TX;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                mmio_addr_out = addr_q;
                mmio_data_out = wdata_q;
                mmio_re_out   = ~we_q;
                mmio_we_out   = we_q;
                rsp_rdata_d   = we_q ? '0 : mmio_rdata_in;
                rsp_err_d     = 1'b0;
                rsp_valid_d   = owner_q ? 2'b10 : 2'b01;
                state_d       = ST_IDLE;
            end

            ST_WAIT_TX: begin
                mmio_addr_out = addr_q;
                // Ready has priority over an expiring timeout.
                if (uart_tx_ready_in) begin
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    cnt_d       = '0;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    // Saturate so an unbounded wait never wraps.
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mmio_arbiter.sv
module tb_mmio_arbiter;
    import mmio_arbiter_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TXTO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mmio_addr_out;
    logic [DW-1:0] mmio_data_out;
    logic          mmio_re_out;
    logic          mmio_we_out;
    logic [DW-1:0] mmio_rdata_in;
    logic          uart_tx_ready_in;

    int checks = 0;
    int passes = 0;

    mmio_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) req0_if ();
    mmio_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) req1_if ();

    mmio_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .TX_TIMEOUT(TXTO)) dut (
        .clk              (clk),
        .rst              (rst),
        .req0             (req0_if),
        .req1             (req1_if),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .mmio_addr_out    (mmio_addr_out),
        .mmio_data_out    (mmio_data_out),
        .mmio_re_out      (mmio_re_out),
        .mmio_we_out      (mmio_we_out),
        .mmio_rdata_in    (mmio_rdata_in),
        .uart_tx_ready_in (uart_tx_ready_in)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        req0_if.valid = 1'b0; req0_if.addr = '0; req0_if.wdata = '0; req0_if.we = 1'b0;
        req1_if.valid = 1'b0; req1_if.addr = '0; req1_if.wdata = '0; req1_if.we = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive_idle();
        repeat (3) next_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({mmio_re_out, mmio_we_out, req0_if.rsp_valid, req1_if.rsp_valid, rsp_err, req0_if.ready, req1_if.ready} !== 7'b0)
            $display("FAIL reset_flags: got %b expected 0000000",
                {mmio_re_out, mmio_we_out, req0_if.rsp_valid, req1_if.rsp_valid, rsp_err, req0_if.ready, req1_if.ready});
        else passes++;
        checks++;
        if ({rsp_rdata, mmio_addr_out, mmio_data_out} !== '0)
            $display("FAIL reset_buses: got rdata=%h addr=%h data=%h expected all 0", rsp_rdata, mmio_addr_out, mmio_data_out);
        else passes++;
        $display("txn reset: outputs sampled");
    endtask

    task automatic test_single_read();
        next_cycle();
        uart_tx_ready_in = 1'b1;
        mmio_rdata_in    = 32'h0000_1234;
        req0_if.valid = 1'b1; req0_if.addr = CYCLE_ADDR; req0_if.we = 1'b0; req0_if.wdata = '0;
        @(negedge clk);
        checks++;
        if ({req1_if.ready, req0_if.ready, mmio_re_out, mmio_we_out} !== 4'b0100)
            $display("FAIL read_accept: got ready1,ready0,re,we=%b expected 0100",
                {req1_if.ready, req0_if.ready, mmio_re_out, mmio_we_out});
        else passes++;
        next_cycle();
        req0_if.valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({mmio_re_out, mmio_we_out, req0_if.rsp_valid} !== 3'b100 || mmio_addr_out !== CYCLE_ADDR)
            $display("FAIL read_strobe: got re,we,rsp0=%b addr=%h expected 100 addr=%h",
                {mmio_re_out, mmio_we_out, req0_if.rsp_valid}, mmio_addr_out, CYCLE_ADDR);
        else passes++;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({req0_if.rsp_valid, req1_if.rsp_valid, rsp_err, mmio_re_out} !== 4'b1000 || rsp_rdata !== 32'h1234)
            $display("FAIL read_rsp: got rsp0,rsp1,err,re=%b rdata=%h expected 1000 rdata=00001234",
                {req0_if.rsp_valid, req1_if.rsp_valid, rsp_err, mmio_re_out}, rsp_rdata);
        else passes++;
        next_cycle();
        @(negedge clk);
        checks++;
        if (req0_if.rsp_valid !== 1'b0)
            $display("FAIL read_rsp_width: got rsp0=%b one cycle later expected 0", req0_if.rsp_valid);
        else passes++;
        $display("txn single_read: req0 rd %h -> %h", CYCLE_ADDR, rsp_rdata);
    endtask

    task automatic test_tie();
        logic [1:0] exp_rdy;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            req0_if.valid = 1'b1; req0_if.addr = CYCLE_ADDR; req0_if.we = 1'b0;
            req1_if.valid = 1'b1; req1_if.addr = INST_ADDR;  req1_if.we = 1'b0;
            @(negedge clk);
            // Accepts land on every other cycle and alternate 0,1,0,1.
            if (k % 2 == 1) exp_rdy = 2'b00;
            else exp_rdy = ((k / 2) % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if ({req1_if.ready, req0_if.ready} !== exp_rdy)
                $display("FAIL tie_order k=%0d: got ready1,ready0=%b expected %b", k, {req1_if.ready, req0_if.ready}, exp_rdy);
            else passes++;
            if (exp_rdy != 2'b00) $display("txn tie k=%0d: grant to req%0d", k, exp_rdy[1]);
        end
        drain();
    endtask

    task automatic test_tx_stall();
        next_cycle();
        uart_tx_ready_in = 1'b0;
        req0_if.valid = 1'b1; req0_if.addr = UART_TX_ADDR; req0_if.we = 1'b1; req0_if.wdata = 32'h41;
        @(negedge clk);
        checks++;
        if (req0_if.ready !== 1'b1)
            $display("FAIL tx_stall_accept: got ready0=%b expected 1", req0_if.ready);
        else passes++;
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            req0_if.valid = 1'b0;
            if (k == 5) uart_tx_ready_in = 1'b1;
            @(negedge clk);
            checks++;
            if ({mmio_re_out, mmio_we_out, req0_if.rsp_valid} !== 3'b000 || mmio_addr_out !== UART_TX_ADDR)
                $display("FAIL tx_stall_hold k=%0d: got re,we,rsp0=%b addr=%h expected 000 addr=%h",
                    k, {mmio_re_out, mmio_we_out, req0_if.rsp_valid}, mmio_addr_out, UART_TX_ADDR);
            else passes++;
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({mmio_re_out, mmio_we_out} !== 2'b01 || mmio_data_out !== 32'h41 || mmio_addr_out !== UART_TX_ADDR)
            $display("FAIL tx_stall_strobe: got re,we=%b data=%h addr=%h expected 01 data=00000041",
                {mmio_re_out, mmio_we_out}, mmio_data_out, mmio_addr_out);
        else passes++;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({req0_if.rsp_valid, rsp_err, mmio_we_out} !== 3'b100 || rsp_rdata !== '0)
            $display("FAIL tx_stall_rsp: got rsp0,err,we=%b rdata=%h expected 100 rdata=0",
                {req0_if.rsp_valid, rsp_err, mmio_we_out}, rsp_rdata);
        else passes++;
        $display("txn tx_stall: req0 wr %h data 41", UART_TX_ADDR);
        drain();
    endtask

    task automatic test_rx_consume();
        int re_cnt = 0;
        int acc = 0;
        int consec = 0;
        logic prev_re = 1'b0;
        uart_tx_ready_in = 1'b1;
        mmio_rdata_in    = 32'h0000_00a5;
        for (int k = 0; k <= 11; k++) begin
            next_cycle();
            req1_if.valid = (k < 10); req1_if.addr = UART_RX_ADDR; req1_if.we = 1'b0;
            @(negedge clk);
            re_cnt += int'(mmio_re_out);
            acc    += int'(req1_if.ready);
            if (mmio_re_out && prev_re) consec++;
            prev_re = mmio_re_out;
        end
        checks++;
        if (acc !== 5) $display("FAIL rx_accepts: got %0d accepts expected 5", acc);
        else passes++;
        checks++;
        if (re_cnt !== acc || consec !== 0)
            $display("FAIL rx_one_strobe: got %0d read strobes (%0d back-to-back) expected %0d single", re_cnt, consec, acc);
        else passes++;
        $display("txn rx_consume: %0d reads of %h", acc, UART_RX_ADDR);
        drain();
    endtask

    task automatic test_tx_timeout();
        next_cycle();
        uart_tx_ready_in = 1'b0;
        req0_if.valid = 1'b1; req0_if.addr = UART_TX_ADDR; req0_if.we = 1'b1; req0_if.wdata = 32'h42;
        @(negedge clk);
        checks++;
        if (req0_if.ready !== 1'b1) $display("FAIL tx_to_accept: got ready0=%b expected 1", req0_if.ready);
        else passes++;
        for (int k = 1; k <= TXTO; k++) begin
            next_cycle();
            req0_if.valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({mmio_re_out, mmio_we_out, req0_if.rsp_valid, req1_if.rsp_valid} !== 4'b0000)
                $display("FAIL tx_to_wait k=%0d: got re,we,rsp0,rsp1=%b expected 0000",
                    k, {mmio_re_out, mmio_we_out, req0_if.rsp_valid, req1_if.rsp_valid});
            else passes++;
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({req0_if.rsp_valid, rsp_err, mmio_we_out} !== 3'b110 || rsp_rdata !== '0)
            $display("FAIL tx_to_rsp: got rsp0,err,we=%b rdata=%h expected 110 rdata=0",
                {req0_if.rsp_valid, rsp_err, mmio_we_out}, rsp_rdata);
        else passes++;
        $display("txn tx_timeout: req0 wr %h dropped", UART_TX_ADDR);
        drain();
    endtask

    task automatic test_reset_mid();
        // Reset while stalled on the TX register.
        next_cycle();
        uart_tx_ready_in = 1'b0;
        req0_if.valid = 1'b1; req0_if.addr = UART_TX_ADDR; req0_if.we = 1'b1; req0_if.wdata = 32'h55;
        @(negedge clk);
        checks++;
        if (req0_if.ready !== 1'b1) $display("FAIL rstw_accept: got ready0=%b expected 1", req0_if.ready);
        else passes++;
        repeat (3) next_cycle();
        req0_if.valid = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mmio_re_out, mmio_we_out, req0_if.rsp_valid, req1_if.rsp_valid, rsp_err} !== 5'b0 ||
            mmio_addr_out !== '0 || rsp_rdata !== '0)
            $display("FAIL rstw_outputs: got re,we,rsp0,rsp1,err=%b addr=%h rdata=%h expected all 0",
                {mmio_re_out, mmio_we_out, req0_if.rsp_valid, req1_if.rsp_valid, rsp_err}, mmio_addr_out, rsp_rdata);
        else passes++;
        uart_tx_ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if ({mmio_we_out, req0_if.rsp_valid} !== 2'b00)
                $display("FAIL rstw_dropped k=%0d: got we,rsp0=%b expected 00", k, {mmio_we_out, req0_if.rsp_valid});
            else passes++;
        end
        // Reset during the strobe cycle.
        next_cycle();
        mmio_rdata_in = 32'h77;
        req0_if.valid = 1'b1; req0_if.addr = CYCLE_ADDR; req0_if.we = 1'b0;
        @(negedge clk);
        next_cycle();
        req0_if.valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mmio_re_out !== 1'b1) $display("FAIL rsti_strobe: got re=%b expected 1", mmio_re_out);
        else passes++;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req0_if.rsp_valid, mmio_re_out} !== 2'b00 || rsp_rdata !== '0)
            $display("FAIL rsti_no_rsp: got rsp0,re=%b rdata=%h expected 00 rdata=0",
                {req0_if.rsp_valid, mmio_re_out}, rsp_rdata);
        else passes++;
        // Requester 0 was granted last before reset; a tie must still go to it.
        next_cycle();
        req0_if.valid = 1'b1; req0_if.addr = CYCLE_ADDR; req0_if.we = 1'b0;
        req1_if.valid = 1'b1; req1_if.addr = INST_ADDR;  req1_if.we = 1'b0;
        @(negedge clk);
        checks++;
        if ({req1_if.ready, req0_if.ready} !== 2'b01)
            $display("FAIL rst_tie: got ready1,ready0=%b expected 01", {req1_if.ready, req0_if.ready});
        else passes++;
        $display("txn reset_mid: stalled write and issuing read aborted");
        drain();
    endtask

    task automatic test_random();
        logic [31:0] addr_tab [6];
        logic        pend [2];
        logic [31:0] r_addr [2];
        logic [31:0] r_wdata [2];
        logic        r_we [2];
        int          free_at, strobe_at, rsp_at;
        int          last, win;
        logic        accept;
        logic [1:0]  exp_rdy;
        logic [1:0]  exp_rsp;
        int          t_owner;
        logic [31:0] t_addr, t_wdata, t_rdata;
        logic        t_we;

        addr_tab = '{UART_CTRL_ADDR, UART_RX_ADDR, UART_TX_ADDR, CYCLE_ADDR, INST_ADDR, CNT_RST_ADDR};
        pend = '{1'b0, 1'b0};
        free_at = 0; strobe_at = -1; rsp_at = -1; last = 1;
        t_owner = 0; t_addr = '0; t_wdata = '0; t_rdata = '0; t_we = 1'b0;
        do_reset();
        uart_tx_ready_in = 1'b1;

        for (int n = 0; n < 300; n++) begin
            next_cycle();
            for (int r = 0; r < 2; r++) begin
                if (pend[r]) begin
                    if ($urandom_range(7) == 0) pend[r] = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    pend[r]    = 1'b1;
                    r_addr[r]  = addr_tab[$urandom_range(5)];
                    r_we[r]    = 1'($urandom_range(1));
                    r_wdata[r] = $urandom;
                end
            end
            req0_if.valid = pend[0]; req0_if.addr = r_addr[0]; req0_if.we = r_we[0]; req0_if.wdata = r_wdata[0];
            req1_if.valid = pend[1]; req1_if.addr = r_addr[1]; req1_if.we = r_we[1]; req1_if.wdata = r_wdata[1];
            mmio_rdata_in = $urandom;
            @(negedge clk);

            accept = (n >= free_at) && (pend[0] || pend[1]);
            if (pend[0] && pend[1]) win = (last == 0) ? 1 : 0;
            else win = pend[1] ? 1 : 0;
            exp_rdy = accept ? ((win == 1) ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if ({req1_if.ready, req0_if.ready} !== exp_rdy)
                $display("FAIL rnd_ready n=%0d: got %b expected %b", n, {req1_if.ready, req0_if.ready}, exp_rdy);
            else passes++;

            checks++;
            if (n == strobe_at) begin
                if ({mmio_re_out, mmio_we_out} !== {~t_we, t_we} || mmio_addr_out !== t_addr ||
                    (t_we && mmio_data_out !== t_wdata))
                    $display("FAIL rnd_strobe n=%0d: got re,we=%b addr=%h data=%h expected %b addr=%h data=%h",
                        n, {mmio_re_out, mmio_we_out}, mmio_addr_out, mmio_data_out, {~t_we, t_we}, t_addr, t_wdata);
                else passes++;
                t_rdata = t_we ? 32'h0 : mmio_rdata_in;
            end else begin
                if ({mmio_re_out, mmio_we_out} !== 2'b00)
                    $display("FAIL rnd_nostrobe n=%0d: got re,we=%b expected 00", n, {mmio_re_out, mmio_we_out});
                else passes++;
            end

            exp_rsp = (n == rsp_at) ? ((t_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if ({req1_if.rsp_valid, req0_if.rsp_valid} !== exp_rsp ||
                (n == rsp_at && (rsp_rdata !== t_rdata || rsp_err !== 1'b0)))
                $display("FAIL rnd_rsp n=%0d: got rsp=%b rdata=%h err=%b expected %b rdata=%h err=0",
                    n, {req1_if.rsp_valid, req0_if.rsp_valid}, rsp_rdata, rsp_err, exp_rsp, t_rdata);
            else passes++;

            if (accept) begin
                t_owner   = win;
                t_addr    = r_addr[win];
                t_wdata   = r_wdata[win];
                t_we      = r_we[win];
                strobe_at = n + 1;
                rsp_at    = n + 2;
                free_at   = n + 2;
                last      = win;
                pend[win] = 1'b0;
                $display("txn rnd n=%0d: req%0d %s addr=%h wdata=%h", n, win, t_we ? "wr" : "rd", t_addr, t_wdata);
            end
        end
        drain();
    endtask

    initial begin
        rst              = 1'b1;
        mmio_rdata_in    = '0;
        uart_tx_ready_in = 1'b1;
        drive_idle();
        test_reset();
        test_single_read();
        test_tie();
        test_tx_stall();
        test_rx_consume();
        test_tx_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mmio_arbiter.md
Name: mmio_arbiter

Overview:
- Shares the single MMIO port (UART control/data, cycle/instruction counters, counter reset) between two requesters: requester 0 is the core memory stage, requester 1 is the debug/bootloader port.
- Serialises accesses so that each access drives the MMIO read or write strobe for exactly one cycle. This guarantees a read of UART RX data consumes exactly one byte.
- Stalls UART TX writes until the transmitter is ready, with an optional timeout.
- Sits between the requesters and the MMIO decode block.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data width.
- TX_TIMEOUT, 1024, maximum cycles to wait for UART TX ready; 0 = wait forever.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an access
- req0_addr  in  AWIDTH  requester 0 address
- req0_wdata  in  DWIDTH  requester 0 write data
- req0_we  in  1  requester 0 write (1) / read (0)
- req0_ready  out  1  requester 0 access accepted this cycle
- req1_valid, req1_addr, req1_wdata, req1_we, req1_ready  same widths and meanings, requester 1
- rsp0_valid  out  1  one-cycle response pulse to requester 0
- rsp1_valid  out  1  one-cycle response pulse to requester 1
- rsp_rdata  out  DWIDTH  read data; qualified by rsp0_valid or rsp1_valid
- rsp_err  out  1  response is a TX timeout drop
- mmio_addr_out  out  AWIDTH  address to MMIO decode
- mmio_data_out  out  DWIDTH  write data to MMIO decode
- mmio_re_out  out  1  MMIO read strobe
- mmio_we_out  out  1  MMIO write strobe
- mmio_rdata_in  in  DWIDTH  MMIO read data (combinational)
- uart_tx_ready_in  in  1  UART transmitter ready

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant = 1, timeout counter 0. A pending transaction is dropped with no rsp pulse.
- FSM states: IDLE, ISSUE, WAIT_TX.
- IDLE:
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last wins (round robin), so after reset requester 0 wins the first tie.
  - reqN_ready is combinational: state==IDLE && grantN.
  - On grant, addr, wdata, we and owner are latched and last_grant is updated.
  - Next state is WAIT_TX if we && addr==UART_TX_ADDR (0x80000008) && !uart_tx_ready_in; otherwise ISSUE.
- ISSUE, exactly 1 cycle:
  - mmio_addr_out and mmio_data_out come from the latched values.
  - mmio_re_out = ~we, mmio_we_out = we.
  - mmio_rdata_in is registered into rsp_rdata (writes register 0).
  - rsp_err is cleared, and the owner's rspN_valid is pulsed on the next cycle.
  - Next state is IDLE.
- WAIT_TX:
  - mmio_addr_out is driven; re/we stay 0; the counter increments each cycle.
  - uart_tx_ready_in=1 → ISSUE, counter cleared.
  - Counter reaches TX_TIMEOUT-1 (TX_TIMEOUT≠0) with ready still 0 → write dropped, rspN_valid pulse with rsp_err=1 and rsp_rdata=0, → IDLE.
  - Ready and timeout in the same cycle: ready wins.
- Latency: accept at cycle T, strobe at T+1, rsp pulse at T+2. Back-to-back accesses are accepted every 2 cycles.
- The rsp pulse of one access and the accept of the next may occur in the same cycle.
- Requesters must hold valid and all fields stable until ready. Deasserting valid before ready is legal (request withdrawn).
- Strobes are never asserted in IDLE or WAIT_TX. At most one strobe is asserted per accepted access.
- Timeout counter width is clog2(TX_TIMEOUT+1) and it saturates (never wraps).

Decomposition:
- Shared defines/package mmio_defs: MMIO address constants (UART_CTRL 0x80000000, UART_RX 0x80000004, UART_TX 0x80000008, CYCLE 0x80000010, INST 0x80000014, CNT_RST 0x80000018) and the FSM state encodings.
- One sub-module, rr_arb2: two-way round-robin grant with a last_grant register and an update-enable input.

Test Plan:
- Single read: req0 read of 0x80000010 with mmio_rdata_in=0x1234 → req0_ready at T, mmio_re_out=1 only at T+1, rsp0_valid with rsp_rdata=0x1234 at T+2, rsp_err=0.
- Tie after reset: both valid, requester 1 reading 0x80000014 → req0 granted first and req1 granted on the next IDLE cycle; order 0,1,0,1 under continuous contention.
- RX single consume: req1 read of 0x80000004 held valid for 10 cycles → mmio_re_out high for exactly one cycle per accepted access.
- TX stall: req0 write 0x41 to 0x80000008 with uart_tx_ready_in=0 for 5 cycles → no strobe during the stall; mmio_we_out with data 0x41 the cycle after ready rises; rsp0_valid with err=0.
- TX timeout: TX_TIMEOUT=8, ready held 0 → no mmio_we_out; rsp0_valid with rsp_err=1 and rsp_rdata=0 after 8 WAIT_TX cycles.
- Reset mid-operation: rst in WAIT_TX or ISSUE → all outputs 0 the next cycle, no rsp pulse; a subsequent tie grants requester 0.
